// File: rtl/ftdi_io_deser.sv
// Multi-channel self-timed serial-to-parallel decoder with start/stop framing per channel.
// Optional parity bit after the data bits: define FTDI_IO_DESER_PARITY_EN.
module ftdi_io_deser #(
  parameter int unsigned CDataLen = 8,
  parameter int unsigned CChCnt   = 1,
  parameter int unsigned CBitDiv  = 16,
  parameter int unsigned CDivLen  = 16
) (
  input  logic                         AClkH,
  input  logic                         AResetHN,
  input  logic [CChCnt-1:0]            ADataI,
  input  logic [CChCnt-1:0]            ARdAck,
  output logic [CChCnt*CDataLen-1:0]   ADataO,
  output logic [CChCnt-1:0]            AValid,
  output logic [CChCnt-1:0]            AFrmErr,
  output logic [CChCnt-1:0]            AOvfErr,
  output logic [CChCnt-1:0]            AParErr,
  output logic                         ABusy
);

  localparam int unsigned CBcW = $clog2(CDataLen) + 1;

  localparam logic [2:0] SIdle  = 3'd0;
  localparam logic [2:0] SStart = 3'd1;
  localparam logic [2:0] SData  = 3'd2;
`ifdef FTDI_IO_DESER_PARITY_EN
  localparam logic [2:0] SPar   = 3'd3;
`endif
  localparam logic [2:0] SStop  = 3'd4;

  localparam logic [CDivLen-1:0] CHalf = CDivLen'(CBitDiv / 2 - 1);
  localparam logic [CDivLen-1:0] CFull = CDivLen'(CBitDiv - 1);
  localparam logic [CBcW-1:0]    CLast = CBcW'(CDataLen - 1);

`ifdef FTDI_IO_DESER_PARITY_EN
  function automatic logic par_err_calc(input logic [CDataLen-1:0] data, input logic par);
    return (^data) ^ par;
  endfunction
`endif

  logic [1:0]        flush_q;
  logic              armed_s;
  logic [CChCnt-1:0] busy_s;

  // Edge detection is held off until the synchroniser has flushed its preset ones,
  // so a line that is already low when reset releases cannot start a frame.
  always_ff @(posedge AClkH or negedge AResetHN) begin
    if (!AResetHN) begin
      flush_q <= 2'd0;
    end else if (flush_q != 2'd3) begin
      flush_q <= flush_q + 2'd1;
    end else begin
      flush_q <= flush_q;
    end
  end

  assign armed_s = (flush_q == 2'd3);
  assign ABusy   = |busy_s;

  for (genvar gi = 0; gi < CChCnt; gi++) begin : g_ch
    logic                sync1_q, sync2_q, prev_q;
    logic [2:0]          state_q, state_d;
    logic [CDivLen-1:0]  cnt_q, cnt_d;
    logic [CDataLen-1:0] shift_q, shift_d;
    logic [CBcW-1:0]     bits_q, bits_d;
    logic                stop_q, stop_d;
    logic                done_q, done_d;
    logic [CDataLen:0]   shift_ext_s;
    logic                fall_s, tick_s;
    logic [CDataLen-1:0] data_q;
    logic                valid_q, frm_q, ovf_q;
`ifdef FTDI_IO_DESER_PARITY_EN
    logic                par_q, par_d;
    logic                perr_q;
`endif

    always_ff @(posedge AClkH or negedge AResetHN) begin
      if (!AResetHN) begin
        sync1_q <= 1'b1;
        sync2_q <= 1'b1;
        prev_q  <= 1'b1;
      end else begin
        sync1_q <= ADataI[gi];
        sync2_q <= sync1_q;
        prev_q  <= sync2_q;
      end
    end

    assign fall_s      = armed_s && prev_q && !sync2_q;
    assign tick_s      = (cnt_q == '0);
    assign shift_ext_s = {shift_q, sync2_q};

    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      shift_d = shift_q;
      bits_d  = bits_q;
      stop_d  = stop_q;
      done_d  = 1'b0;
`ifdef FTDI_IO_DESER_PARITY_EN
      par_d   = par_q;
`endif
      case (state_q)
        SIdle: begin
          if (fall_s) begin
            cnt_d   = CHalf;
            state_d = SStart;
          end else begin
            state_d = SIdle;
          end
        end
        SStart: begin
          if (!tick_s) begin
            cnt_d = cnt_q - CDivLen'(1);
          end else if (sync2_q) begin
            state_d = SIdle;
          end else begin
            cnt_d   = CFull;
            bits_d  = '0;
            state_d = SData;
          end
        end
        SData: begin
          if (!tick_s) begin
            cnt_d = cnt_q - CDivLen'(1);
          end else begin
            shift_d = shift_ext_s[CDataLen-1:0];
            cnt_d   = CFull;
            if (bits_q == CLast) begin
`ifdef FTDI_IO_DESER_PARITY_EN
              state_d = SPar;
`else
              state_d = SStop;
`endif
            end else begin
              bits_d = bits_q + CBcW'(1);
            end
          end
        end
`ifdef FTDI_IO_DESER_PARITY_EN
        SPar: begin
          if (!tick_s) begin
            cnt_d = cnt_q - CDivLen'(1);
          end else begin
            par_d   = sync2_q;
            cnt_d   = CFull;
            state_d = SStop;
          end
        end
`endif
        SStop: begin
          if (!tick_s) begin
            cnt_d = cnt_q - CDivLen'(1);
          end else begin
            // FSM returns to Idle at once; the word is published one cycle later via done_q.
            stop_d  = sync2_q;
            done_d  = 1'b1;
            state_d = SIdle;
          end
        end
        default: begin
          state_d = SIdle;
          cnt_d   = '0;
        end
      endcase
    end

    always_ff @(posedge AClkH or negedge AResetHN) begin
      if (!AResetHN) begin
        state_q <= SIdle;
        cnt_q   <= '0;
        shift_q <= '0;
        bits_q  <= '0;
        stop_q  <= 1'b0;
        done_q  <= 1'b0;
`ifdef FTDI_IO_DESER_PARITY_EN
        par_q   <= 1'b0;
`endif
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        shift_q <= shift_d;
        bits_q  <= bits_d;
        stop_q  <= stop_d;
        done_q  <= done_d;
`ifdef FTDI_IO_DESER_PARITY_EN
        par_q   <= par_d;
`endif
      end
    end

    // An ack on the completion edge consumes the old word, so no overrun is flagged.
    always_ff @(posedge AClkH or negedge AResetHN) begin
      if (!AResetHN) begin
        data_q  <= '0;
        valid_q <= 1'b0;
        frm_q   <= 1'b0;
        ovf_q   <= 1'b0;
`ifdef FTDI_IO_DESER_PARITY_EN
        perr_q  <= 1'b0;
`endif
      end else if (done_q) begin
        data_q  <= shift_q;
        valid_q <= 1'b1;
        frm_q   <= ~stop_q;
        ovf_q   <= (valid_q && !ARdAck[gi]) || (ovf_q && !ARdAck[gi]);
`ifdef FTDI_IO_DESER_PARITY_EN
        perr_q  <= par_err_calc(shift_q, par_q);
`endif
      end else if (ARdAck[gi] && valid_q) begin
        valid_q <= 1'b0;
        ovf_q   <= 1'b0;
      end else begin
        valid_q <= valid_q;
        ovf_q   <= ovf_q;
      end
    end

    assign ADataO[gi*CDataLen +: CDataLen] = data_q;
    assign AValid[gi]  = valid_q;
    assign AFrmErr[gi] = frm_q;
    assign AOvfErr[gi] = ovf_q;
`ifdef FTDI_IO_DESER_PARITY_EN
    assign AParErr[gi] = perr_q;
`else
    assign AParErr[gi] = 1'b0;
`endif
    assign busy_s[gi]  = (state_q != SIdle);
  end

endmodule

// File: tb/tb_ftdi_io_deser.sv
// Scoreboard bench for ftdi_io_deser: 2 channels, 8 data bits, 16 clocks per bit.
module tb_ftdi_io_deser;

  localparam int CDataLen = 8;
  localparam int CChCnt   = 2;
  localparam int CBitDiv  = 16;
  localparam int CDivLen  = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  din = 2'b11;
  logic [1:0]  ack = 2'b00;
  logic [15:0] dout;
  logic [1:0]  valid, frm, ovf, perr;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int rise_cyc [2];
  logic [1:0] prev_valid = 2'b00;

  typedef struct {
    int         ch;
    logic [7:0] data;
    logic       frm;
    logic       perr;
  } exp_t;
  exp_t sb_q[$];

  ftdi_io_deser #(
    .CDataLen(CDataLen), .CChCnt(CChCnt), .CBitDiv(CBitDiv), .CDivLen(CDivLen)
  ) dut (
    .AClkH(clk), .AResetHN(rst_n), .ADataI(din), .ARdAck(ack),
    .ADataO(dout), .AValid(valid), .AFrmErr(frm), .AOvfErr(ovf),
    .AParErr(perr), .ABusy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (valid[i] && !prev_valid[i]) rise_cyc[i] = cyc;
    end
    prev_valid = valid;
  end

  task automatic send_bit(input int ch, input logic b);
    din[ch] = b;
    repeat (CBitDiv) @(negedge clk);
  endtask

  task automatic send_frame(input int ch, input logic [7:0] d, input logic stop,
                            input logic par, input bit push);
    exp_t e;
    e.ch = ch; e.data = d; e.frm = ~stop;
`ifdef FTDI_IO_DESER_PARITY_EN
    e.perr = (^d) ^ par;
`else
    e.perr = 1'b0;
`endif
    if (push) sb_q.push_back(e);
    send_bit(ch, 1'b0);
    for (int i = 7; i >= 0; i--) send_bit(ch, d[i]);
`ifdef FTDI_IO_DESER_PARITY_EN
    send_bit(ch, par);
`endif
    send_bit(ch, stop);
    din[ch] = 1'b1;
  endtask

  task automatic check_word(input string name);
    exp_t e;
    int   t;
    t = 0;
    if (sb_q.size() == 0) begin
      n_checks++; n_errors++;
      $display("FAIL %s: scoreboard empty, got data=%h", name, dout);
      return;
    end
    e = sb_q.pop_front();
    while (!valid[e.ch] && t < 400) begin
      @(negedge clk); t++;
    end
    n_checks++;
    if (!valid[e.ch]) begin
      n_errors++;
      $display("FAIL %s_timeout: valid=%b required ch%0d valid", name, valid, e.ch);
      return;
    end
    n_checks++;
    if (dout[e.ch*8 +: 8] !== e.data) begin
      n_errors++;
      $display("FAIL %s_data: got %h expected %h", name, dout[e.ch*8 +: 8], e.data);
    end
    n_checks++;
    if (frm[e.ch] !== e.frm) begin
      n_errors++;
      $display("FAIL %s_frm: got %b expected %b", name, frm[e.ch], e.frm);
    end
    n_checks++;
    if (perr[e.ch] !== e.perr) begin
      n_errors++;
      $display("FAIL %s_par: got %b expected %b", name, perr[e.ch], e.perr);
    end
  endtask

  task automatic do_ack(input int ch);
    ack[ch] = 1'b1;
    @(negedge clk);
    ack[ch] = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_checks++;
    if ({dout, valid, frm, ovf, perr, busy} !== 25'd0) begin
      n_errors++;
      $display("FAIL reset_outputs: got %h expected 0", {dout, valid, frm, ovf, perr, busy});
    end
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || valid !== 2'b00) begin
      n_errors++;
      $display("FAIL idle_after_reset: busy=%b valid=%b expected 0/00", busy, valid);
    end
  endtask

  task automatic test_basic();
    int t0, lat;
    t0 = cyc;
    send_frame(0, 8'hA5, 1'b1, 1'b0, 1'b1);
    check_word("basic_a5");
    lat = rise_cyc[0] - t0;
    n_checks++;
    if (lat < 150 || lat > 160) begin
      n_errors++;
      $display("FAIL basic_latency: got %0d cycles expected 150..160", lat);
    end
    n_checks++;
    if (valid !== 2'b01) begin
      n_errors++;
      $display("FAIL basic_valid: got %b expected 01", valid);
    end
    do_ack(0);
    n_checks++;
    if (valid !== 2'b00) begin
      n_errors++;
      $display("FAIL basic_ack: got %b expected 00", valid);
    end
  endtask

  task automatic test_frame_err();
    send_frame(0, 8'h3C, 1'b0, 1'b0, 1'b1);
    check_word("frmerr_3c");
    do_ack(0);
    repeat (4) @(negedge clk);
    send_frame(0, 8'h01, 1'b1, 1'b1, 1'b1);
    check_word("frmerr_01");
    do_ack(0);
  endtask

  task automatic test_back_to_back();
    send_frame(0, 8'h11, 1'b1, 1'b0, 1'b1);
    check_word("b2b_11");
    send_frame(0, 8'h22, 1'b1, 1'b0, 1'b1);
    check_word("b2b_22");
    n_checks++;
    if (ovf[0] !== 1'b1) begin
      n_errors++;
      $display("FAIL b2b_ovf: got %b expected 1", ovf[0]);
    end
    do_ack(0);
    n_checks++;
    if (valid[0] !== 1'b0 || ovf[0] !== 1'b0) begin
      n_errors++;
      $display("FAIL b2b_ack: valid=%b ovf=%b expected 0/0", valid[0], ovf[0]);
    end
  endtask

  task automatic test_glitch();
    din[1] = 1'b0;
    repeat (4) @(negedge clk);
    din[1] = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if (busy !== 1'b1) begin
      n_errors++;
      $display("FAIL glitch_busy: got %b expected 1", busy);
    end
    repeat (20) @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || valid !== 2'b00) begin
      n_errors++;
      $display("FAIL glitch_idle: busy=%b valid=%b expected 0/00", busy, valid);
    end
    fork
      send_frame(0, 8'h7E, 1'b1, 1'b0, 1'b1);
      begin
        repeat (40) @(negedge clk);
        din[1] = 1'b0;
        repeat (4) @(negedge clk);
        din[1] = 1'b1;
      end
    join
    check_word("glitch_7e");
    n_checks++;
    if (valid[1] !== 1'b0) begin
      n_errors++;
      $display("FAIL glitch_ch1: got valid %b expected 0", valid[1]);
    end
    send_frame(1, 8'h96, 1'b1, 1'b0, 1'b1);
    check_word("ch1_96");
    do_ack(1);
  endtask

  task automatic test_reset_mid();
    send_bit(0, 1'b0);
    send_bit(0, 1'b1);
    send_bit(0, 1'b0);
    send_bit(0, 1'b1);
    rst_n  = 1'b0;
    din[0] = 1'b1;
    din[1] = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({dout, valid, frm, ovf, busy} !== 23'd0) begin
      n_errors++;
      $display("FAIL rstmid_outputs: got %h expected 0", {dout, valid, frm, ovf, busy});
    end
    rst_n = 1'b1;
    repeat (100) @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || valid !== 2'b00) begin
      n_errors++;
      $display("FAIL rstmid_lowline: busy=%b valid=%b expected 0/00", busy, valid);
    end
    din[1] = 1'b1;
    repeat (4) @(negedge clk);
    send_frame(0, 8'hC3, 1'b1, 1'b0, 1'b1);
    check_word("rstmid_c3");
    do_ack(0);
  endtask

`ifdef FTDI_IO_DESER_PARITY_EN
  task automatic test_parity();
    send_frame(0, 8'h0F, 1'b1, 1'b0, 1'b1);
    check_word("par_good");
    do_ack(0);
    send_frame(0, 8'h0F, 1'b1, 1'b1, 1'b1);
    check_word("par_bad");
    do_ack(0);
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_frame_err();
    test_back_to_back();
    test_glitch();
    test_reset_mid();
`ifdef FTDI_IO_DESER_PARITY_EN
    test_parity();
`endif
    n_checks++;
    if (sb_q.size() != 0) begin
      n_errors++;
      $display("FAIL scoreboard_drain: %0d entries left expected 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
